uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per UART frame and width of m_axis_tdata.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rxd  input  1  asynchronous serial line, idle high.
REQ-005 m_axis_tdata  output  DATA_WIDTH  received byte.
REQ-006 m_axis_tvalid  output  1  tdata holds an unaccepted byte.
REQ-007 m_axis_tready  input  1  downstream accepts the byte.
REQ-008 busy  output  1  high whenever the receiver FSM is not IDLE.
REQ-009 overrun_error  output  1  one-cycle pulse: byte completed while output still full.
REQ-010 frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 parity_error  output  1  one-cycle pulse: parity mismatch.
REQ-012 prescale  input  16  bit period = prescale*8 clk cycles; prescale 0 is treated as 1.

Function
REQ-013 rxd passes through a 2-flop synchronizer (both flops reset to 1) before any use.
REQ-014 prescale is latched on start-bit detection and held constant for the whole frame.
REQ-015 FSM states: IDLE, START, DATA, PARITY (present only when the parity feature is built in), STOP.
REQ-016 IDLE -> START when synchronized rxd is 0; the sample counter loads prescale*4-1 (half bit).
REQ-017 START: at counter expiry, rxd=1 -> IDLE (false start, no output, no error); rxd=0 -> DATA with the counter reloaded to prescale*8-1.
REQ-018 DATA: sample once per bit period at mid-bit, LSB first, shifting into a DATA_WIDTH register; after DATA_WIDTH samples go to PARITY, or to STOP when parity is built out.
REQ-019 PARITY: sample one bit at mid-bit; it must equal the even parity of the data bits (XOR of data XOR parity bit = 0).
REQ-020 STOP: sample at mid-stop; return to IDLE on the same cycle, so a new start bit can be detected on the next cycle.
REQ-021 Byte valid = stop bit is 1 and no parity error; a valid byte is offered one clk after the mid-stop sample.
REQ-022 Stop bit 0: frame_error pulses for 1 cycle; the byte is discarded.
REQ-023 Parity mismatch: parity_error pulses for 1 cycle; the byte is discarded; if the stop bit is also 0, both error flags pulse.
REQ-024 Output is a single-entry register: tvalid stays high and tdata stays stable until tvalid&tready.
REQ-025 Valid byte completes while tvalid=1 and tready=0: overrun_error pulses for 1 cycle; the new byte is dropped and the old byte is retained.
REQ-026 Valid byte completes on the same cycle as tvalid&tready: the new byte loads, tvalid remains 1, no overrun.
REQ-027 Counter width shall be at least 19 bits so that prescale=0xFFFF does not wrap.

Reset
REQ-028 On rst: FSM=IDLE, counters=0, shift register=0, synchronizer flops=1.
REQ-029 On rst: m_axis_tdata=0, m_axis_tvalid=0, busy=0, overrun_error=0, frame_error=0, parity_error=0.
REQ-030 rst asserted mid-frame aborts the frame with no output and no error pulse.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: PARITY state and even-parity checking are included; the frame is start + DATA_WIDTH + parity + stop.
REQ-032 Macro UART_RX_PARITY_EN undefined: frame is 8N1-style (start + DATA_WIDTH + stop); no PARITY state; parity_error is tied to 0.

Verification
REQ-033 prescale=1, tready=1, send 0xA5 8N1 -> tvalid=1 with tdata=0xA5 exactly 1 clk after mid-stop; frame_error=0.
REQ-034 prescale=1, tready=0, send 0x3C then 0x7E -> tdata stays 0x3C, one overrun_error pulse, then tready=1 accepts 0x3C and tvalid=0.
REQ-035 prescale=1, send 0x55 with the stop bit driven 0 -> one frame_error pulse, tvalid stays 0.
REQ-036 prescale=1, rxd low for 2 clk only -> FSM returns to IDLE, busy drops, no tvalid, no error pulse.
REQ-037 UART_RX_PARITY_EN defined, send 0x01 with parity bit 0 -> one parity_error pulse, no tvalid; parity bit 1 -> tdata=0x01.
REQ-038 rst pulsed during bit 4 of 0xFF, then send 0x12 -> only 0x12 is delivered.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with single-entry stream output; UART_RX_PARITY_EN adds even-parity checking
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    output logic                  parity_error,
    input  logic [15:0]           prescale
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state, state_next;
    logic                  rxd_meta, rxd_sync;
    logic [15:0]           prescale_eff, prescale_q;
    logic [18:0]           cnt, half_load, full_load;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  expire, last_bit, frame_done, par_fail;
`ifdef UART_RX_PARITY_EN
    logic                  parity_bit;
`endif

    assign prescale_eff = (prescale == 16'd0) ? 16'd1 : prescale;
    // Half-bit load uses the live input since prescale_q is captured on the same edge.
    assign half_load    = {1'b0, prescale_eff, 2'b00} - 19'd1;
    assign full_load    = {prescale_q, 3'b000} - 19'd1;
    assign expire       = (cnt == 19'd0);
    assign last_bit     = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign frame_done   = (state == STOP) && expire;

`ifdef UART_RX_PARITY_EN
    assign par_fail = ^{shift, parity_bit};
`else
    assign par_fail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (!rxd_sync) state_next = START;
            START:  if (expire) state_next = rxd_sync ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (expire && last_bit) state_next = PARITY;
            PARITY: if (expire) state_next = STOP;
`else
            DATA:   if (expire && last_bit) state_next = STOP;
`endif
            STOP:   if (expire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q <= 16'd0;
            cnt        <= 19'd0;
            bit_cnt    <= '0;
            shift      <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (!rxd_sync) begin
                prescale_q <= prescale_eff;
                cnt        <= half_load;
                bit_cnt    <= '0;
            end
        end else if (!expire) begin
            cnt <= cnt - 19'd1;
        end else begin
            cnt <= full_load;
            if (state == DATA) begin
                shift   <= {rxd_sync, shift[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (state == PARITY) begin
                parity_bit <= rxd_sync;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            frame_error   <= frame_done && !rxd_sync;
            parity_error  <= frame_done && par_fail;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            // A byte accepted on this edge frees the slot for the arriving one.
            if (frame_done && rxd_sync && !par_fail) begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    m_axis_tdata  <= shift;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    overrun_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        busy, overrun_error, frame_error, parity_error;
    logic [15:0] prescale = 16'd1;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .rxd(rxd),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .busy(busy),
        .overrun_error(overrun_error), .frame_error(frame_error),
        .parity_error(parity_error), .prescale(prescale)
    );

    always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   fe_cnt = 0, pe_cnt = 0, oe_cnt = 0;
    logic prev_tvalid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_error === 1'b1) fe_cnt++;
            if (parity_error === 1'b1) pe_cnt++;
            if (overrun_error === 1'b1) oe_cnt++;
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got tdata %0h expected no beat", m_axis_tdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("tdata", int'(m_axis_tdata), int'(e.data));
                    if (e.cyc != 0 && !prev_tvalid) check("tvalid_latency", cyc, e.cyc);
                end
            end
            prev_tvalid = (m_axis_tvalid === 1'b1);
        end
    end

    function automatic int latency(input int p);
        return 3 + 4 * p + 8 * p * NB;
    endfunction

    task automatic drive_bit(input logic b, input int p);
        rxd = b;
        repeat (8 * p) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stop_bit, input int p);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
`ifdef UART_RX_PARITY_EN
        drive_bit(par, p);
`endif
        drive_bit(stop_bit, p);
        rxd = 1'b1;
    endtask

    task automatic expect_byte(input logic [7:0] d, input int p, input logic timed);
        exp_t e;
        e.data = d;
        e.cyc  = timed ? cyc + latency(p) : 0;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int fe0, pe0, oe0;

    task automatic snap();
        fe0 = fe_cnt; pe0 = pe_cnt; oe0 = oe_cnt;
    endtask

    task automatic check_errs(input string tag, input int fe, input int pe, input int oe);
        check({tag, "_frame_err"}, fe_cnt - fe0, fe);
        check({tag, "_parity_err"}, pe_cnt - pe0, pe);
        check({tag, "_overrun_err"}, oe_cnt - oe0, oe);
    endtask

    initial begin
        idle(3);
        check("rst_tvalid", int'(m_axis_tvalid), 0);
        check("rst_tdata", int'(m_axis_tdata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_err", int'(frame_error), 0);
        check("rst_parity_err", int'(parity_error), 0);
        check("rst_overrun_err", int'(overrun_error), 0);
        rst = 1'b0;
        idle(4);

        // 0xA5 with exact one-cycle-after-mid-stop latency
        snap();
        expect_byte(8'hA5, 1, 1'b1);
        send(8'hA5, ^8'hA5, 1'b1, 1);
        idle(16);
        check_errs("a5", 0, 0, 0);
        check("a5_tvalid_after", int'(m_axis_tvalid), 0);

        // prescale 0 behaves as 1
        prescale = 16'd0;
        expect_byte(8'h81, 1, 1'b1);
        send(8'h81, ^8'h81, 1'b1, 1);
        idle(16);

        // slower bit rate
        prescale = 16'd3;
        expect_byte(8'h4B, 3, 1'b1);
        send(8'h4B, ^8'h4B, 1'b1, 3);
        idle(40);
        prescale = 16'd1;

        // overrun: second byte dropped, first retained
        snap();
        m_axis_tready = 1'b0;
        send(8'h3C, ^8'h3C, 1'b1, 1);
        send(8'h7E, ^8'h7E, 1'b1, 1);
        idle(16);
        check_errs("overrun", 0, 0, 1);
        check("overrun_tvalid", int'(m_axis_tvalid), 1);
        check("overrun_tdata", int'(m_axis_tdata), 8'h3C);
        expect_byte(8'h3C, 1, 1'b0);
        m_axis_tready = 1'b1;
        idle(2);
        check("overrun_drained", int'(m_axis_tvalid), 0);

        // stop bit low
        snap();
        send(8'h55, ^8'h55, 1'b0, 1);
        idle(30);
        check_errs("frame", 1, 0, 0);
        check("frame_tvalid", int'(m_axis_tvalid), 0);
        check("frame_busy", int'(busy), 0);

        // 2-cycle glitch is a false start
        snap();
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(1);
        check("glitch_busy_high", int'(busy), 1);
        idle(20);
        check("glitch_busy_low", int'(busy), 0);
        check("glitch_tvalid", int'(m_axis_tvalid), 0);
        check_errs("glitch", 0, 0, 0);

`ifdef UART_RX_PARITY_EN
        snap();
        send(8'h01, 1'b0, 1'b1, 1);
        idle(16);
        check_errs("parity_bad", 0, 1, 0);
        check("parity_bad_tvalid", int'(m_axis_tvalid), 0);
        expect_byte(8'h01, 1, 1'b1);
        send(8'h01, 1'b1, 1'b1, 1);
        idle(16);
`endif

        // reset in the middle of bit 4 of 0xFF, then 0x12
        snap();
        drive_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1);
        rxd = 1'b1;
        idle(4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(4 + 8 * (NB - 5));
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_tvalid", int'(m_axis_tvalid), 0);
        expect_byte(8'h12, 1, 1'b1);
        send(8'h12, ^8'h12, 1'b1, 1);
        idle(16);
        check_errs("rstmid", 0, 0, 0);

        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
